up_dn_counter_arbiter: RTL

Two-requester round-robin controller that owns the command inputs (Load/Up/Down/IN) of the 5-bit saturating up/down counter and shares it between two clients. Each client issues one operation (up, down, or load) per request and receives the resulting count. Operations the counter would silently ignore (up at 31, down at 0) are rejected with an error flag instead of being issued. After reset the block loads a known initial value into the counter before accepting any request, because the counter itself has no reset.

---
 rtl/up_dn_counter_arbiter_if.sv | 36 +++
 rtl/up_dn_counter_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/up_dn_counter_arbiter_if.sv
//==============================================================================
// Module : up_dn_counter_arbiter_if
// Client-side request/response bundle for the two-client counter arbiter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface up_dn_counter_arbiter_if #(
  parameter int WIDTH = 5
);
  logic             req_a;
  logic             req_b;
  logic [1:0]       op_a;
  logic [1:0]       op_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output req_a, req_b, op_a, op_b, data_a, data_b,
    input  gnt_a, gnt_b, done_a, done_b, err, result, busy
  );

  modport slave (
    input  req_a, req_b, op_a, op_b, data_a, data_b,
    output gnt_a, gnt_b, done_a, done_b, err, result, busy
  );
endinterface

`default_nettype wire

// File: rtl/up_dn_counter_arbiter.sv
//==============================================================================
// Module : up_dn_counter_arbiter
// Round-robin two-client front end for a reset-less saturating up/down counter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module up_dn_counter_arbiter #(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  up_dn_counter_arbiter_if.slave bus,
  output logic                   cnt_load,
  output logic                   cnt_up,
  output logic                   cnt_down,
  output logic [WIDTH-1:0]       cnt_in,
  input  logic [WIDTH-1:0]       cnt_value,
  input  logic                   cnt_high,
  input  logic                   cnt_low
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] c_op_up   = 2'b00;
  localparam logic [1:0] c_op_down = 2'b01;
  localparam logic [1:0] c_op_load = 2'b10;
  localparam logic [1:0] c_op_rsvd = 2'b11;

  state_t           r_state;
  logic             r_init_sent;
  logic             r_rr_b;
  logic             r_owner_b;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_done_a;
  logic             r_done_b;
  logic             r_err;
  logic             r_busy;
  logic             r_load;
  logic             r_up;
  logic             r_down;
  logic [WIDTH-1:0] r_cnt_in;

  logic             w_any_req;
  logic             w_pick_b;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic             w_reject;

  // B wins when it is the only requester or when the pointer favours it.
  assign w_any_req = bus.req_a | bus.req_b;
  assign w_pick_b  = bus.req_b & (~bus.req_a | r_rr_b);
  assign w_op      = w_pick_b ? bus.op_b   : bus.op_a;
  assign w_data    = w_pick_b ? bus.data_b : bus.data_a;
  assign w_reject  = (w_op == c_op_rsvd)
                   | ((w_op == c_op_up)   & cnt_high)
                   | ((w_op == c_op_down) & cnt_low);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_sent <= 1'b0;
      r_rr_b      <= 1'b0;
      r_owner_b   <= 1'b0;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_load      <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_cnt_in    <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // The counter has no reset: push INIT_VAL once before serving anyone.
          if (!r_init_sent) begin
            r_init_sent <= 1'b1;
            r_load      <= 1'b1;
            r_cnt_in    <= INIT_VAL;
            r_busy      <= 1'b1;
          end else begin
            r_load   <= 1'b0;
            r_cnt_in <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_b <= w_pick_b;
            r_gnt_a   <= ~w_pick_b;
            r_gnt_b   <= w_pick_b;
            r_busy    <= 1'b1;
            if (w_reject) begin
              r_done_a <= ~w_pick_b;
              r_done_b <= w_pick_b;
              r_err    <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_up     <= (w_op == c_op_up);
              r_down   <= (w_op == c_op_down);
              r_load   <= (w_op == c_op_load);
              r_cnt_in <= (w_op == c_op_load) ? w_data : '0;
              r_state  <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          r_up     <= 1'b0;
          r_down   <= 1'b0;
          r_load   <= 1'b0;
          r_cnt_in <= '0;
          r_done_a <= ~r_owner_b;
          r_done_b <= r_owner_b;
          r_err    <= 1'b0;
          r_state  <= ST_RESP;
        end

        ST_RESP: begin
          r_done_a <= 1'b0;
          r_done_b <= 1'b0;
          r_err    <= 1'b0;
          r_gnt_a  <= 1'b0;
          r_gnt_b  <= 1'b0;
          r_busy   <= 1'b0;
          r_rr_b   <= ~r_owner_b;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign cnt_load = r_load;
  assign cnt_up   = r_up;
  assign cnt_down = r_down;
  assign cnt_in   = r_cnt_in;

  assign bus.gnt_a  = r_gnt_a;
  assign bus.gnt_b  = r_gnt_b;
  assign bus.done_a = r_done_a;
  assign bus.done_b = r_done_b;
  assign bus.err    = r_err;
  assign bus.busy   = r_busy;
  // The counter has already settled by the response cycle, so its output is the result.
  assign bus.result = (r_done_a | r_done_b) ? cnt_value : '0;

endmodule

`default_nettype wire
